// File: rtl/pipreg_elastic.sv
// Elastic valid/ready pipeline-register chain with per-stage flush and bubble collapse.
// Optional performance counters are built when PIPREG_PERF_EN is defined.
module pipreg_elastic #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_STAGES = 1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    input  logic [NUM_STAGES-1:0]                 flush_mask,
    output logic [$clog2(NUM_STAGES+1)-1:0]       occupancy,
    output logic [CNT_WIDTH-1:0]                  perf_stall_cnt,
    output logic [CNT_WIDTH-1:0]                  perf_flush_cnt
);

    localparam int unsigned OCC_W = $clog2(NUM_STAGES + 1);
    localparam int unsigned LAST  = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] v;
    logic [DATA_WIDTH-1:0] d   [NUM_STAGES];
    logic [DATA_WIDTH-1:0] src [NUM_STAGES];
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] snd;
    logic [NUM_STAGES-1:0] rcv;
    logic [OCC_W-1:0]      v_cnt;

    // Ready chain walked from the output end; a stage is open if empty, flushed or draining.
    always_comb begin : ready_chain
        logic rdy;
        rdy         = out_ready;
        stage_ready = '0;
        snd         = '0;
        for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
            snd[k]         = v[k] & ~flush_mask[k] & rdy;
            rdy            = ~v[k] | flush_mask[k] | rdy;
            stage_ready[k] = rdy;
        end
    end

    // Stage 0 is fed by the upstream handshake, every later stage by its predecessor.
    always_comb begin
        rcv    = '0;
        rcv[0] = in_valid & stage_ready[0];
        src[0] = in_data;
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            rcv[k] = snd[k-1];
            src[k] = d[k-1];
        end
    end

    always_comb begin
        v_cnt = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            v_cnt = v_cnt + OCC_W'(v[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                if (rcv[k]) begin
                    v[k] <= 1'b1;
                    d[k] <= src[k];
                end else if (snd[k] | flush_mask[k]) begin
                    v[k] <= 1'b0;
                end
            end
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign in_ready  = reset | stage_ready[0];
    assign out_valid = ~reset & v[LAST] & ~flush_mask[LAST];
    assign out_data  = reset ? '0 : d[LAST];
    assign occupancy = reset ? '0 : v_cnt;

`ifdef PIPREG_PERF_EN
    localparam int unsigned SUM_W = CNT_WIDTH + 1;

    logic [OCC_W-1:0]     kill_cnt;
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] flush_q;
    logic [SUM_W-1:0]     flush_sum;

    always_comb begin
        kill_cnt = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            kill_cnt = kill_cnt + OCC_W'(v[k] & flush_mask[k]);
        end
    end

    assign flush_sum = {1'b0, flush_q} + SUM_W'(kill_cnt);

    // Saturating counters: stall cycles and live entries killed by flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (in_valid & ~in_ready & ~(&stall_q)) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
            flush_q <= flush_sum[CNT_WIDTH] ? '1 : flush_sum[CNT_WIDTH-1:0];
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipreg_elastic.sv
// Bench for pipreg_elastic: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a slot-movement model.
module tb_pipreg_elastic;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned OW = 3;
`ifdef PIPREG_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [NS-1:0] flush_mask;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] perf_stall_cnt;
    logic [CW-1:0] perf_flush_cnt;

    pipreg_elastic #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush_mask(flush_mask), .occupancy(occupancy),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    // Model: which slots hold a payload, their data, and counter totals.
    logic [NS-1:0] mv = '0;
    logic [DW-1:0] md [NS];
    int unsigned   m_stall = 0;
    int unsigned   m_flush = 0;

    logic [DW-1:0] outq [$];
    int            outc [$];
    int            inc  [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // A slot will be vacant after this edge if it holds nothing live or its entry moves on.
    function automatic logic [NS:0] free_slots(input logic [NS-1:0] flm, input logic ordy);
        logic [NS:0] fr;
        fr[NS] = ordy;
        for (int k = NS - 1; k >= 0; k--) begin
            fr[k] = !(mv[k] && !flm[k]) || fr[k+1];
        end
        return fr;
    endfunction

    always @(posedge clock) begin
        logic [NS:0]   fr;
        logic [NS-1:0] nv;
        logic [DW-1:0] nd [NS];
        cyc++;
        if (reset) begin
            armed   = 1'b1;
            mv      = '0;
            for (int k = 0; k < NS; k++) md[k] = '0;
            m_stall = 0;
            m_flush = 0;
        end else if (armed) begin
            fr = free_slots(flush_mask, out_ready);
            if (in_valid && !fr[0]) m_stall++;
            m_flush += $countones(mv & flush_mask);
            nv = '0;
            for (int k = 0; k < NS; k++) nd[k] = md[k];
            for (int k = NS - 1; k >= 0; k--) begin
                if (mv[k] && !flush_mask[k]) begin
                    if (k == NS - 1) begin
                        if (!out_ready) nv[k] = 1'b1;
                    end else if (fr[k+1]) begin
                        nv[k+1] = 1'b1;
                        nd[k+1] = md[k];
                    end else begin
                        nv[k] = 1'b1;
                    end
                end
            end
            if (in_valid && fr[0]) begin
                nv[0] = 1'b1;
                nd[0] = in_data;
            end
            mv = nv;
            for (int k = 0; k < NS; k++) md[k] = nd[k];
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        logic [NS:0] fr;
        if (armed) begin
            fr = free_slots(flush_mask, out_ready);
            check("in_ready",  64'(in_ready),  reset ? 64'd1 : 64'(fr[0]));
            check("out_valid", 64'(out_valid), reset ? 64'd0 : 64'(mv[NS-1] && !flush_mask[NS-1]));
            check("out_data",  64'(out_data),  reset ? 64'd0 : 64'(md[NS-1]));
            check("occupancy", 64'(occupancy), reset ? 64'd0 : 64'($countones(mv)));
            check("perf_stall_cnt", 64'(perf_stall_cnt), PERF ? 64'(m_stall) : 64'd0);
            check("perf_flush_cnt", 64'(perf_flush_cnt), PERF ? 64'(m_flush) : 64'd0);
            if (!reset && out_valid && out_ready) begin
                outq.push_back(out_data);
                outc.push_back(cyc);
            end
            if (!reset && in_valid && in_ready) inc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_data    = '0;
        flush_mask = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        outq.delete();
        outc.delete();
        inc.delete();
    endtask

    task automatic fill(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_outq(input string name, input logic [DW-1:0] exp [$]);
        check({name, "_count"}, 64'(outq.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < outq.size()) check(name, 64'(outq[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        logic [DW-1:0] exp [$];
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b0;
        @(negedge clock);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_occupancy", 64'(occupancy), 64'd0);
        tick();

        // Streaming at full rate.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h1000 + DW'(i);
            @(negedge clock);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        exp = {};
        for (int i = 0; i < 8; i++) exp.push_back(32'h1000 + DW'(i));
        check_outq("stream_data", exp);
        if (outc.size() == 8 && inc.size() == 8) begin
            check("stream_latency", 64'(outc[0] - inc[0]), 64'(NS));
            for (int i = 1; i < 8; i++) check("stream_back_to_back", 64'(outc[i] - outc[0]), 64'(i));
        end

        // Back-pressure on a full chain.
        do_reset();
        fill(32'hA0, 4);
        in_valid = 1'b1;
        in_data  = 32'hA4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_occupancy", 64'(occupancy), 64'd4);
            check("bp_out_data", 64'(out_data), 64'hA0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        outq.delete();
        @(negedge clock);
        check("bp_stall_cnt", 64'(perf_stall_cnt), PERF ? 64'd5 : 64'd0);
        repeat (6) tick();
        exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        check_outq("bp_drain", exp);

        // Bubble collapse under a stalled output.
        do_reset();
        fill(32'hB0, 1);
        tick();
        fill(32'hB1, 1);
        repeat (4) tick();
        @(negedge clock);
        check("bubble_occupancy", 64'(occupancy), 64'd2);
        check("bubble_in_ready", 64'(in_ready), 64'd1);
        check("bubble_out_data", 64'(out_data), 64'hB0);
        tick();
        out_ready = 1'b1;
        outq.delete();
        outc.delete();
        repeat (3) tick();
        exp = '{32'hB0, 32'hB1};
        check_outq("bubble_drain", exp);
        if (outc.size() == 2) check("bubble_packed", 64'(outc[1] - outc[0]), 64'd1);

        // Flush two stages while refilling stage 0.
        do_reset();
        fill(32'hC0, 4);
        in_valid   = 1'b1;
        in_data    = 32'hD0;
        flush_mask = 4'b0011;
        @(negedge clock);
        check("flush_hole_in_ready", 64'(in_ready), 64'd1);
        tick();
        idle_inputs();
        @(negedge clock);
        check("flush_occupancy", 64'(occupancy), 64'd3);
        check("flush_cnt", 64'(perf_flush_cnt), PERF ? 64'd2 : 64'd0);
        tick();
        out_ready = 1'b1;
        outq.delete();
        repeat (5) tick();
        exp = '{32'hC0, 32'hC1, 32'hD0};
        check_outq("flush_drain", exp);

        // Flush of the output stage while downstream is ready.
        do_reset();
        fill(32'hE0, 1);
        repeat (3) tick();
        out_ready  = 1'b1;
        flush_mask = 4'b1000;
        outq.delete();
        @(negedge clock);
        check("oflush_out_valid", 64'(out_valid), 64'd0);
        tick();
        flush_mask = '0;
        @(negedge clock);
        check("oflush_occupancy", 64'(occupancy), 64'd0);
        repeat (2) tick();
        check("oflush_never_out", 64'(outq.size()), 64'd0);

        // Reset in the middle of traffic, with a handshake in the reset cycle.
        do_reset();
        fill(32'hF0, 3);
        in_valid   = 1'b1;
        in_data    = 32'hF3;
        flush_mask = 4'b0001;
        tick();
        flush_mask = '0;
        in_data    = 32'hF4;
        reset      = 1'b1;
        @(negedge clock);
        check("rst_in_ready_during", 64'(in_ready), 64'd1);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(perf_flush_cnt), 64'd0);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = $urandom;
            out_ready  = ($urandom_range(0, 9) < 7);
            flush_mask = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
